// File: rtl/cond_pkg.sv
// Shared types and helpers for the multi-context condition-code unit.
package cond_pkg;

    // Condition flags of one context. Packed so that {n,z,p,c,v} maps directly onto cc_rd.
    typedef struct packed {
        logic n;
        logic z;
        logic p;
        logic c;
        logic v;
    } cc_flags_t;

    // Extended branch conditions, selected by IR[11:9] when IR[12] is set.
    typedef enum logic [2:0] {
        EXT_CS = 3'b000,   // carry set
        EXT_CC = 3'b001,   // carry clear
        EXT_VS = 3'b010,   // overflow set
        EXT_VC = 3'b011,   // overflow clear
        EXT_HI = 3'b100,   // unsigned higher
        EXT_LS = 3'b101,   // unsigned lower or same
        EXT_AL = 3'b110,   // always
        EXT_NV = 3'b111    // never
    } ext_cond_e;

    localparam cc_flags_t CC_RESET = '0;

    // Width of a context index: clog2(n), but at least one bit.
    function automatic int ctx_w(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Bus between the datapath/ISDU and the condition-code unit.
interface cond_unit_if #(
    parameter int DATA_W = 16,
    parameter int CTX_W  = 2
);
    logic              LD_CC;
    logic [CTX_W-1:0]  wr_ctx;
    logic [DATA_W-1:0] Bus;
    logic              carry_in;
    logic              ovf_in;
    logic              CLR_CC;
    logic              LD_BEN;
    logic [CTX_W-1:0]  br_ctx;
    logic [15:0]       IR;
    logic              BEN;
    logic              ben_valid;
    logic              ben_err;
    logic [4:0]        cc_rd;

    modport master (
        output LD_CC, wr_ctx, Bus, carry_in, ovf_in, CLR_CC, LD_BEN, br_ctx, IR,
        input  BEN, ben_valid, ben_err, cc_rd
    );

    modport slave (
        input  LD_CC, wr_ctx, Bus, carry_in, ovf_in, CLR_CC, LD_BEN, br_ctx, IR,
        output BEN, ben_valid, ben_err, cc_rd
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluation for one set of flags.
module cond_eval
    import cond_pkg::*;
#(
    parameter int EXT_MODE = 1
) (
    input  cc_flags_t  flags,
    input  logic [3:0] ir_code,   // IR[12:9]
    output logic       ben
);

    // Decode either the classic nzp mask or the extended condition code.
    always_comb begin
        ben = 1'b0;
        if ((EXT_MODE != 0) && ir_code[3]) begin
            case (ext_cond_e'(ir_code[2:0]))
                EXT_CS:  ben = flags.c;
                EXT_CC:  ben = ~flags.c;
                EXT_VS:  ben = flags.v;
                EXT_VC:  ben = ~flags.v;
                EXT_HI:  ben = flags.c & ~flags.z;
                EXT_LS:  ben = ~flags.c | flags.z;
                EXT_AL:  ben = 1'b1;
                EXT_NV:  ben = 1'b0;
                default: ben = 1'b0;
            endcase
        end else begin
            ben = (ir_code[2] & flags.n) | (ir_code[1] & flags.z) | (ir_code[0] & flags.p);
        end
    end

endmodule

// File: rtl/cond_unit.sv
// Multi-context NZP/CV condition-code store with registered BEN evaluation.
module cond_unit
    import cond_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int N_CTX    = 4,
    parameter int EXT_MODE = 1,
    parameter int FWD      = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    cond_unit_if.slave  cu
);

    localparam int CTX_W = ctx_w(N_CTX);

    cc_flags_t        flags_r [N_CTX];
    logic [N_CTX-1:0] init_r;
    cc_flags_t        new_flags_s;
    cc_flags_t        rd_flags_s;
    logic             rd_init_s;
    logic             rd_hit_s;
    cc_flags_t        eval_flags_s;
    logic             eval_init_s;
    logic             ben_eval_s;
    logic             ben_r;
    logic             ben_valid_r;
    logic             ben_err_r;

    // Flags produced by an LD_CC this cycle; C/V stay zero without extended mode.
    always_comb begin
        new_flags_s   = CC_RESET;
        new_flags_s.n = cu.Bus[DATA_W-1];
        new_flags_s.z = (cu.Bus == {DATA_W{1'b0}});
        new_flags_s.p = ~cu.Bus[DATA_W-1] & (cu.Bus != {DATA_W{1'b0}});
        if (EXT_MODE != 0) begin
            new_flags_s.c = cu.carry_in;
            new_flags_s.v = cu.ovf_in;
        end else begin
            new_flags_s.c = 1'b0;
            new_flags_s.v = 1'b0;
        end
    end

    // Per-context flag storage; LD_CC beats CLR_CC, out-of-range writes match no entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < N_CTX; i++) begin
                flags_r[i] <= CC_RESET;
            end
            init_r <= '0;
        end else begin
            for (int i = 0; i < N_CTX; i++) begin
                if (cu.LD_CC && (cu.wr_ctx == CTX_W'(i))) begin
                    flags_r[i] <= new_flags_s;
                    init_r[i]  <= 1'b1;
                end else if (cu.CLR_CC && (cu.wr_ctx == CTX_W'(i))) begin
                    flags_r[i] <= CC_RESET;
                    init_r[i]  <= 1'b0;
                end else begin
                    flags_r[i] <= flags_r[i];
                    init_r[i]  <= init_r[i];
                end
            end
        end
    end

    // Read mux for br_ctx; an out-of-range index hits nothing and reads as zero.
    always_comb begin
        rd_flags_s = CC_RESET;
        rd_init_s  = 1'b0;
        rd_hit_s   = 1'b0;
        for (int i = 0; i < N_CTX; i++) begin
            if (cu.br_ctx == CTX_W'(i)) begin
                rd_flags_s = flags_r[i];
                rd_init_s  = init_r[i];
                rd_hit_s   = 1'b1;
            end else begin
                rd_hit_s = rd_hit_s;
            end
        end
    end

    // Same-cycle bypass of a write to the context being evaluated.
    always_comb begin
        eval_flags_s = rd_flags_s;
        eval_init_s  = rd_init_s;
        if ((FWD != 0) && rd_hit_s && (cu.wr_ctx == cu.br_ctx)) begin
            if (cu.LD_CC) begin
                eval_flags_s = new_flags_s;
                eval_init_s  = 1'b1;
            end else if (cu.CLR_CC) begin
                eval_flags_s = CC_RESET;
                eval_init_s  = 1'b0;
            end else begin
                eval_init_s = rd_init_s;
            end
        end else begin
            eval_init_s = rd_init_s;
        end
    end

    cond_eval #(
        .EXT_MODE (EXT_MODE)
    ) u_eval (
        .flags   (eval_flags_s),
        .ir_code (cu.IR[12:9]),
        .ben     (ben_eval_s)
    );

    // Registered BEN result; invalid or uninitialised contexts force BEN low with an error.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ben_r       <= 1'b0;
            ben_valid_r <= 1'b0;
            ben_err_r   <= 1'b0;
        end else if (cu.LD_BEN) begin
            ben_valid_r <= 1'b1;
            if (rd_hit_s && eval_init_s) begin
                ben_r     <= ben_eval_s;
                ben_err_r <= 1'b0;
            end else begin
                ben_r     <= 1'b0;
                ben_err_r <= 1'b1;
            end
        end else begin
            ben_r       <= ben_r;
            ben_valid_r <= 1'b0;
            ben_err_r   <= ben_err_r;
        end
    end

    assign cu.BEN       = ben_r;
    assign cu.ben_valid = ben_valid_r;
    assign cu.ben_err   = ben_err_r;
    assign cu.cc_rd     = rd_flags_s;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: three configurations driven with identical stimulus.
module tb_cond_unit;

    logic Clk;
    logic Reset;
    int   errors;
    int   checks;

    // a: defaults (N_CTX=4, EXT, FWD); b: no forwarding; c: N_CTX=3, pure NZP
    cond_unit_if #(.DATA_W(16), .CTX_W(2)) ifa ();
    cond_unit_if #(.DATA_W(16), .CTX_W(2)) ifb ();
    cond_unit_if #(.DATA_W(16), .CTX_W(2)) ifc ();

    cond_unit #(.DATA_W(16), .N_CTX(4), .EXT_MODE(1), .FWD(1)) dut_a (.Clk(Clk), .Reset(Reset), .cu(ifa));
    cond_unit #(.DATA_W(16), .N_CTX(4), .EXT_MODE(1), .FWD(0)) dut_b (.Clk(Clk), .Reset(Reset), .cu(ifb));
    cond_unit #(.DATA_W(16), .N_CTX(3), .EXT_MODE(0), .FWD(1)) dut_c (.Clk(Clk), .Reset(Reset), .cu(ifc));

    assign ifb.LD_CC = ifa.LD_CC;   assign ifc.LD_CC = ifa.LD_CC;
    assign ifb.wr_ctx = ifa.wr_ctx; assign ifc.wr_ctx = ifa.wr_ctx;
    assign ifb.Bus = ifa.Bus;       assign ifc.Bus = ifa.Bus;
    assign ifb.carry_in = ifa.carry_in; assign ifc.carry_in = ifa.carry_in;
    assign ifb.ovf_in = ifa.ovf_in; assign ifc.ovf_in = ifa.ovf_in;
    assign ifb.CLR_CC = ifa.CLR_CC; assign ifc.CLR_CC = ifa.CLR_CC;
    assign ifb.LD_BEN = ifa.LD_BEN; assign ifc.LD_BEN = ifa.LD_BEN;
    assign ifb.br_ctx = ifa.br_ctx; assign ifc.br_ctx = ifa.br_ctx;
    assign ifb.IR = ifa.IR;         assign ifc.IR = ifa.IR;

    always #5 Clk = ~Clk;

    function automatic logic [15:0] ir_of(input logic [3:0] code);
        return {3'b000, code, 9'b0_0000_0000};
    endfunction

    task automatic idle();
        ifa.LD_CC = 1'b0; ifa.CLR_CC = 1'b0; ifa.LD_BEN = 1'b0;
        ifa.carry_in = 1'b0; ifa.ovf_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ctx, input logic [15:0] val, input logic c, input logic v);
        idle();
        ifa.LD_CC = 1'b1; ifa.wr_ctx = ctx; ifa.Bus = val; ifa.carry_in = c; ifa.ovf_in = v;
        tick();
        idle();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle();
        ifa.wr_ctx = 2'd0; ifa.br_ctx = 2'd0; ifa.Bus = 16'h0000; ifa.IR = 16'h0000;
        repeat (2) tick();
        checks++; if (ifa.ben_valid !== 1'b0 || ifa.BEN !== 1'b0 || ifa.ben_err !== 1'b0) begin
            errors++; $display("FAIL reset_outs: got valid=%0b ben=%0b err=%0b expected 0 0 0", ifa.ben_valid, ifa.BEN, ifa.ben_err); end
        checks++; if (ifa.cc_rd !== 5'b00000) begin
            errors++; $display("FAIL reset_cc: got %b expected 00000", ifa.cc_rd); end
        Reset = 1'b1;
        tick();
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd0; ifa.IR = ir_of(4'b0111);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b0 || ifa.ben_valid !== 1'b1 || ifa.ben_err !== 1'b1) begin
            errors++; $display("FAIL reset_uninit: got ben=%0b valid=%0b err=%0b expected 0 1 1", ifa.BEN, ifa.ben_valid, ifa.ben_err); end
        tick();
        checks++; if (ifa.ben_valid !== 1'b0) begin
            errors++; $display("FAIL valid_pulse: got %0b expected 0", ifa.ben_valid); end
    endtask

    task automatic test_nzp();
        load(2'd1, 16'h8000, 1'b0, 1'b0);
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd1; ifa.IR = ir_of(4'b0100);
        tick();
        checks++; if (ifa.BEN !== 1'b1 || ifa.ben_err !== 1'b0 || ifa.ben_valid !== 1'b1) begin
            errors++; $display("FAIL nzp_n: got ben=%0b err=%0b valid=%0b expected 1 0 1", ifa.BEN, ifa.ben_err, ifa.ben_valid); end
        ifa.IR = ir_of(4'b0011);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b0 || ifa.ben_valid !== 1'b1) begin
            errors++; $display("FAIL nzp_zp_b2b: got ben=%0b valid=%0b expected 0 1", ifa.BEN, ifa.ben_valid); end
        load(2'd1, 16'h0000, 1'b0, 1'b0);
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd1; ifa.IR = ir_of(4'b0010);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b1 || ifc.BEN !== 1'b1) begin
            errors++; $display("FAIL nzp_z: got a=%0b c=%0b expected 1 1", ifa.BEN, ifc.BEN); end
        tick();
        checks++; if (ifa.BEN !== 1'b1) begin
            errors++; $display("FAIL ben_hold: got %0b expected 1", ifa.BEN); end
    endtask

    task automatic test_forward();
        load(2'd2, 16'h0000, 1'b0, 1'b0);
        ifa.LD_CC = 1'b1; ifa.wr_ctx = 2'd2; ifa.Bus = 16'h0005;
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd2; ifa.IR = ir_of(4'b0001);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b1 || ifa.ben_err !== 1'b0) begin
            errors++; $display("FAIL fwd_on: got ben=%0b err=%0b expected 1 0", ifa.BEN, ifa.ben_err); end
        checks++; if (ifb.BEN !== 1'b0 || ifb.ben_err !== 1'b0) begin
            errors++; $display("FAIL fwd_off: got ben=%0b err=%0b expected 0 0", ifb.BEN, ifb.ben_err); end
        checks++; if (ifa.cc_rd !== 5'b00100) begin
            errors++; $display("FAIL fwd_stored: got %b expected 00100", ifa.cc_rd); end
        ifa.CLR_CC = 1'b1; ifa.wr_ctx = 2'd2;
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd2; ifa.IR = ir_of(4'b0001);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b0 || ifa.ben_err !== 1'b1) begin
            errors++; $display("FAIL fwd_clr_on: got ben=%0b err=%0b expected 0 1", ifa.BEN, ifa.ben_err); end
        checks++; if (ifb.BEN !== 1'b1 || ifb.ben_err !== 1'b0) begin
            errors++; $display("FAIL fwd_clr_off: got ben=%0b err=%0b expected 1 0", ifb.BEN, ifb.ben_err); end
        checks++; if (ifa.cc_rd !== 5'b00000 || ifb.cc_rd !== 5'b00000) begin
            errors++; $display("FAIL clr_cc: got a=%b b=%b expected 00000", ifa.cc_rd, ifb.cc_rd); end
        ifa.LD_CC = 1'b1; ifa.CLR_CC = 1'b1; ifa.wr_ctx = 2'd2; ifa.Bus = 16'h8000;
        tick();
        idle();
        checks++; if (ifa.cc_rd !== 5'b10000) begin
            errors++; $display("FAIL ld_beats_clr: got %b expected 10000", ifa.cc_rd); end
    endtask

    task automatic test_isolation();
        load(2'd0, 16'hFFFF, 1'b0, 1'b0);
        load(2'd3, 16'h0001, 1'b0, 1'b0);
        ifa.br_ctx = 2'd0; #1;
        checks++; if (ifa.cc_rd !== 5'b10000) begin
            errors++; $display("FAIL iso_ctx0: got %b expected 10000", ifa.cc_rd); end
        ifa.br_ctx = 2'd3; #1;
        checks++; if (ifa.cc_rd !== 5'b00100) begin
            errors++; $display("FAIL iso_ctx3: got %b expected 00100", ifa.cc_rd); end
        checks++; if (ifc.cc_rd !== 5'b00000) begin
            errors++; $display("FAIL range_drop: got %b expected 00000", ifc.cc_rd); end
        ifa.CLR_CC = 1'b1; ifa.wr_ctx = 2'd3;
        tick();
        idle();
        ifa.br_ctx = 2'd0; #1;
        checks++; if (ifa.cc_rd !== 5'b10000 || ifc.cc_rd !== 5'b10000) begin
            errors++; $display("FAIL iso_after_clr: got a=%b c=%b expected 10000", ifa.cc_rd, ifc.cc_rd); end
        ifa.br_ctx = 2'd3; #1;
        checks++; if (ifa.cc_rd !== 5'b00000) begin
            errors++; $display("FAIL iso_clr3: got %b expected 00000", ifa.cc_rd); end
    endtask

    task automatic test_extended();
        load(2'd1, 16'h0003, 1'b1, 1'b0);
        ifa.br_ctx = 2'd1; #1;
        checks++; if (ifa.cc_rd !== 5'b00110 || ifc.cc_rd !== 5'b00100) begin
            errors++; $display("FAIL ext_flags: got a=%b c=%b expected 00110 00100", ifa.cc_rd, ifc.cc_rd); end
        ifa.LD_BEN = 1'b1; ifa.IR = ir_of(4'b1100);
        tick();
        checks++; if (ifa.BEN !== 1'b1) begin
            errors++; $display("FAIL ext_hi: got %0b expected 1", ifa.BEN); end
        ifa.IR = ir_of(4'b1011);
        tick();
        checks++; if (ifa.BEN !== 1'b1 || ifa.ben_valid !== 1'b1) begin
            errors++; $display("FAIL ext_vc: got ben=%0b valid=%0b expected 1 1", ifa.BEN, ifa.ben_valid); end
        ifa.IR = ir_of(4'b1111);
        tick();
        checks++; if (ifa.BEN !== 1'b0) begin
            errors++; $display("FAIL ext_nv: got %0b expected 0", ifa.BEN); end
        ifa.IR = ir_of(4'b1000);
        tick();
        idle();
        checks++; if (ifa.BEN !== 1'b1 || ifc.BEN !== 1'b0 || ifc.ben_err !== 1'b0) begin
            errors++; $display("FAIL ext_cs: got a=%0b c=%0b c_err=%0b expected 1 0 0", ifa.BEN, ifc.BEN, ifc.ben_err); end
    endtask

    task automatic test_abort_range();
        @(negedge Clk);
        ifa.LD_BEN = 1'b1; ifa.br_ctx = 2'd1; ifa.IR = ir_of(4'b0010);
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (ifa.ben_valid !== 1'b0 || ifa.cc_rd !== 5'b00000) begin
            errors++; $display("FAIL abort: got valid=%0b cc=%b expected 0 00000", ifa.ben_valid, ifa.cc_rd); end
        tick();
        idle();
        Reset = 1'b1;
        tick();
        checks++; if (ifa.ben_valid !== 1'b0 || ifb.ben_valid !== 1'b0) begin
            errors++; $display("FAIL abort_after: got a=%0b b=%0b expected 0 0", ifa.ben_valid, ifb.ben_valid); end
        load(2'd3, 16'h0005, 1'b0, 1'b0);
        ifa.br_ctx = 2'd3; #1;
        checks++; if (ifc.cc_rd !== 5'b00000 || ifa.cc_rd !== 5'b00100) begin
            errors++; $display("FAIL range_wr: got c=%b a=%b expected 00000 00100", ifc.cc_rd, ifa.cc_rd); end
        ifa.LD_BEN = 1'b1; ifa.IR = ir_of(4'b0111);
        tick();
        idle();
        checks++; if (ifc.ben_err !== 1'b1 || ifc.BEN !== 1'b0 || ifc.ben_valid !== 1'b1) begin
            errors++; $display("FAIL range_br: got err=%0b ben=%0b valid=%0b expected 1 0 1", ifc.ben_err, ifc.BEN, ifc.ben_valid); end
        checks++; if (ifa.ben_err !== 1'b0 || ifa.BEN !== 1'b1) begin
            errors++; $display("FAIL inrange_br: got err=%0b ben=%0b expected 0 1", ifa.ben_err, ifa.BEN); end
    endtask

    initial begin
        Clk = 1'b0;
        Reset = 1'b0;
        errors = 0;
        checks = 0;
        test_reset();
        test_nzp();
        test_forward();
        test_isolation();
        test_extended();
        test_abort_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
